// File: rtl/mem_request_scheduler_if.sv
// Request payload type and the valid/ready bundle shared by the requesters,
// the scheduler and the downstream memory-request port.

package ctrl_signal_types;
  typedef struct packed {
    logic [3:0]  id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_request_t;
endpackage

interface mem_request_scheduler_if #(
  parameter int unsigned NUM_INPUT_PORT = 4
);
  import ctrl_signal_types::*;

  logic [NUM_INPUT_PORT-1:0] in_valid;
  logic [NUM_INPUT_PORT-1:0] in_ready;
  mem_request_t              in_request [NUM_INPUT_PORT];
  logic                      out_valid;
  logic                      out_ready;
  mem_request_t              out_request;

  // Requester/consumer side: drives the inputs, sinks the scheduled output
  modport master (
    output in_valid, in_request, out_ready,
    input  in_ready, out_valid, out_request
  );

  // Scheduler side
  modport slave (
    input  in_valid, in_request, out_ready,
    output in_ready, out_valid, out_request
  );
endinterface

// File: rtl/mem_request_scheduler.sv
// Weighted round-robin scheduler: N requesters share one registered
// memory-request output; a granted port keeps ownership for up to its weight
// in consecutive beats.
// Optional per-port grant counters: define MEM_REQUEST_SCHEDULER_GRANT_CNT_EN.

module mem_request_scheduler
  import ctrl_signal_types::*;
#(
  parameter int unsigned NUM_INPUT_PORT = 4,
  parameter int unsigned WEIGHT_W       = 4
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  mem_request_scheduler_if.slave                  bus,
  input  logic [NUM_INPUT_PORT-1:0][WEIGHT_W-1:0] weight_cfg,
  output logic                                    idle
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
  ,
  input  logic                                    clear_cnt,
  output logic [NUM_INPUT_PORT-1:0][31:0]         grant_cnt
`endif
);

  localparam int unsigned IDX_W    = $clog2(NUM_INPUT_PORT);
  localparam logic [0:0]  ST_ARB   = 1'b0;
  localparam logic [0:0]  ST_BURST = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [IDX_W-1:0]          cur_q, cur_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]       cred_q, cred_d;
  logic                      out_valid_q;
  mem_request_t              out_request_q;

  logic                      load_en;
  logic                      keep_owner;
  logic                      found;
  logic [IDX_W-1:0]          sel;
  logic [IDX_W-1:0]          start;
  int unsigned               pos;
  logic                      xfer;
  logic [WEIGHT_W-1:0]       eff_w;
  logic [NUM_INPUT_PORT-1:0] in_ready_c;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] r;
    if (32'(i) == NUM_INPUT_PORT - 1) r = '0;
    else                              r = i + IDX_W'(1);
    return r;
  endfunction

  assign load_en    = ~out_valid_q | bus.out_ready;
  assign keep_owner = (state_q == ST_BURST) && bus.in_valid[cur_q];

  // Port selection: current owner if still valid, else rotating search
  always_comb begin
    found = 1'b0;
    sel   = cur_q;
    start = ptr_q;
    pos   = 0;
    if (keep_owner) begin
      found = 1'b1;
    end else begin
      if (state_q == ST_BURST) start = next_idx(cur_q);
      for (int unsigned i = 0; i < NUM_INPUT_PORT; i++) begin
        pos = 32'(start) + i;
        if (pos >= NUM_INPUT_PORT) pos = pos - NUM_INPUT_PORT;
        if (!found && bus.in_valid[IDX_W'(pos)]) begin
          found = 1'b1;
          sel   = IDX_W'(pos);
        end
      end
    end
  end

  assign xfer  = reset_n & load_en & found;
  assign eff_w = (weight_cfg[sel] == '0) ? WEIGHT_W'(1) : weight_cfg[sel];

  // Accept strobe to the selected port only
  always_comb begin
    in_ready_c = '0;
    if (xfer) in_ready_c[sel] = 1'b1;
  end

  // Next ownership/credit state
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    if (load_en) begin
      if (keep_owner) begin
        if (cred_q == WEIGHT_W'(1)) begin
          state_d = ST_ARB;
          ptr_d   = next_idx(cur_q);
          cred_d  = '0;
        end else begin
          cred_d = cred_q - WEIGHT_W'(1);
        end
      end else begin
        if (state_q == ST_BURST) begin
          state_d = ST_ARB;
          ptr_d   = next_idx(cur_q);
          cred_d  = '0;
        end
        if (found) begin
          if (eff_w == WEIGHT_W'(1)) begin
            state_d = ST_ARB;
            ptr_d   = next_idx(sel);
            cred_d  = '0;
          end else begin
            state_d = ST_BURST;
            cur_d   = sel;
            cred_d  = eff_w - WEIGHT_W'(1);
          end
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_ARB;
      cur_q   <= '0;
      ptr_q   <= '0;
      cred_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
    end
  end

  // Output register: load on transfer, drop valid when drained with no new beat
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_request_q <= '0;
    end else if (xfer) begin
      out_valid_q   <= 1'b1;
      out_request_q <= bus.in_request[sel];
    end else if (bus.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_request = out_request_q;
  assign idle = (state_q == ST_ARB) && !out_valid_q && (bus.in_valid == '0);

`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
  // Saturating per-port accepted-beat counters; clear beats increment
  always_ff @(posedge clk) begin
    if (!reset_n || clear_cnt) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_INPUT_PORT; i++) begin
        if (in_ready_c[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_scheduler.sv
// Self-checking bench for mem_request_scheduler: directed scenarios followed
// by randomized traffic, all checked against a transaction-level model.

module tb_mem_request_scheduler;
  import ctrl_signal_types::*;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N-1:0][WW-1:0]   weight_cfg;
  logic                   idle;
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
  logic                   clear_cnt;
  logic [N-1:0][31:0]     grant_cnt;
  logic [31:0]            m_cnt [N];
`endif

  mem_request_scheduler_if #(.NUM_INPUT_PORT(N)) bus ();

  mem_request_scheduler #(.NUM_INPUT_PORT(N), .WEIGHT_W(WW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .weight_cfg (weight_cfg),
    .idle       (idle)
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
    ,
    .clear_cnt  (clear_cnt),
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner port (-1 = none), beats still allowed for it,
  // round-robin start port, and the expected output register.
  int           owner;
  int           left;
  int           rr;
  logic         m_ov;
  mem_request_t m_req;
  mem_request_t req_arr [N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which port the scheduler should accept from this cycle (-1 = none)
  function automatic int pick(input logic [N-1:0] v, input logic ordy);
    int from;
    if (m_ov && !ordy) return -1;
    if (owner >= 0 && v[owner]) return owner;
    from = (owner >= 0) ? (owner + 1) % N : rr;
    for (int k = 0; k < N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Advance the model across one clock edge
  task automatic commit(input logic rn, input logic [N-1:0] v, input logic ordy, input int g);
    int w;
    if (!rn) begin
      owner = -1; left = 0; rr = 0; m_ov = 1'b0; m_req = '0;
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
      for (int p = 0; p < N; p++) m_cnt[p] = 32'd0;
`endif
      return;
    end
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
    if (clear_cnt) begin
      for (int p = 0; p < N; p++) m_cnt[p] = 32'd0;
    end else if (g >= 0 && m_cnt[g] != 32'hFFFF_FFFF) begin
      m_cnt[g] = m_cnt[g] + 32'd1;
    end
`endif
    if (!m_ov || ordy) begin
      if (owner >= 0 && !v[owner]) begin
        rr = (owner + 1) % N;
        owner = -1;
      end
      if (g >= 0) begin
        m_ov  = 1'b1;
        m_req = req_arr[g];
        if (owner == g) begin
          left--;
          if (left == 0) begin
            owner = -1;
            rr = (g + 1) % N;
          end
        end else begin
          w = (weight_cfg[g] == '0) ? 1 : int'(weight_cfg[g]);
          if (w == 1) begin
            rr = (g + 1) % N;
          end else begin
            owner = g;
            left  = w - 1;
          end
        end
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  // One cycle: drive at negedge, check mid-low-phase, advance model at posedge.
  // exp_sel: -2 = no directed grant check, -1 = no grant, else expected port.
  task automatic step(input logic rn, input logic [N-1:0] v, input logic ordy, input int exp_sel);
    int         g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] oh;
    logic [95:0]  r;
    reset_n       = rn;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    for (int p = 0; p < N; p++) begin
      r = {$urandom(), $urandom(), $urandom()};
      req_arr[p] = mem_request_t'(r[$bits(mem_request_t)-1:0]);
      bus.in_request[p] = req_arr[p];
    end
    #1;
    g = rn ? pick(v, ordy) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
    if (exp_sel != -2) begin
      oh = '0;
      if (exp_sel >= 0) oh[exp_sel] = 1'b1;
      chk("grant_port", 128'(bus.in_ready), 128'(oh));
    end
    chk("out_valid", 128'(bus.out_valid), 128'(m_ov));
    chk("out_request", 128'(bus.out_request), 128'(m_req));
    chk("idle", 128'(idle), 128'(owner < 0 && !m_ov && v == '0));
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
    for (int p = 0; p < N; p++) chk("grant_cnt", 128'(grant_cnt[p]), 128'(m_cnt[p]));
`endif
    @(posedge clk);
    commit(rn, v, ordy, g);
    @(negedge clk);
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight_cfg[0] = WW'(w0);
    weight_cfg[1] = WW'(w1);
    weight_cfg[2] = WW'(w2);
    weight_cfg[3] = WW'(w3);
  endtask

  initial begin
    int seq [10];
    logic [N-1:0] rv;

    owner = -1; left = 0; rr = 0; m_ov = 1'b0; m_req = '0;
    reset_n = 1'b0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    for (int p = 0; p < N; p++) begin
      req_arr[p] = '0;
      bus.in_request[p] = '0;
    end
    set_w(1, 1, 1, 1);
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
    clear_cnt = 1'b0;
    for (int p = 0; p < N; p++) m_cnt[p] = 32'd0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset with all ports valid, then first grant to port 0
    step(1'b0, 4'b1111, 1'b1, -1);
    step(1'b0, 4'b1111, 1'b1, -1);
    step(1'b1, 4'b1111, 1'b1, 0);

    // Weights {2,1,3,0}, all valid, no backpressure
    set_w(2, 1, 3, 0);
    step(1'b0, 4'b1111, 1'b1, -1);
    seq = '{0, 0, 1, 2, 2, 2, 3, 0, 0, 1};
    for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, 1'b1, seq[i]);

    // Early burst end: port 1 drops after 2 beats, port 3 taken with no bubble
    set_w(1, 4, 1, 1);
    step(1'b0, 4'b0000, 1'b1, -1);
    step(1'b1, 4'b1010, 1'b1, 1);
    step(1'b1, 4'b1010, 1'b1, 1);
    step(1'b1, 4'b1001, 1'b1, 3);
    step(1'b1, 4'b1001, 1'b1, 0);
    step(1'b1, 4'b0000, 1'b1, -1);

    // Backpressure mid-burst: output frozen, burst resumes afterwards
    set_w(1, 1, 4, 1);
    step(1'b0, 4'b0000, 1'b1, -1);
    step(1'b1, 4'b0100, 1'b1, 2);
    step(1'b1, 4'b0100, 1'b1, 2);
    repeat (5) step(1'b1, 4'b1111, 1'b0, -1);
    step(1'b1, 4'b1111, 1'b1, 2);
    step(1'b1, 4'b1111, 1'b1, 2);
    step(1'b1, 4'b1111, 1'b1, 3);

    // Reset while port 2 owns the channel with two beats left
    step(1'b0, 4'b0000, 1'b1, -1);
    step(1'b1, 4'b0100, 1'b1, 2);
    step(1'b1, 4'b0100, 1'b1, 2);
    step(1'b0, 4'b1111, 1'b1, -1);
    step(1'b1, 4'b1111, 1'b1, 0);

`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
    // Ten beats from port 1, then a clear during a beat
    step(1'b0, 4'b0000, 1'b1, -1);
    repeat (10) step(1'b1, 4'b0010, 1'b1, 1);
    chk("grant_cnt_ten", 128'(grant_cnt[1]), 128'(32'd10));
    clear_cnt = 1'b1;
    step(1'b1, 4'b0010, 1'b1, 1);
    clear_cnt = 1'b0;
    chk("grant_cnt_clear", 128'(grant_cnt[1]), 128'(32'd0));
`endif

    // Randomized traffic with occasional weight changes and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(19) == 0) begin
        set_w($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
      end
`ifdef MEM_REQUEST_SCHEDULER_GRANT_CNT_EN
      clear_cnt = ($urandom_range(29) == 0);
`endif
      rv = N'($urandom());
      step(($urandom_range(99) != 0), rv, ($urandom_range(9) < 7), -2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
